// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame scheduler.
// Holds the default frame geometry, the FFT no-response timeout, the read-side
// FSM state encoding and the bit-reversal helper used to map output order.
package fft_pkg;

  localparam int unsigned N       = 32;
  localparam int unsigned DW      = 8;
  localparam int unsigned LOG2N   = $clog2(N);
  localparam int unsigned TIMEOUT = 64;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StWait,
    StDrain
  } rd_state_e;

  // Reverse the low 'width' bits of k; bits above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) begin
        r[i] = k[int'(width) - 1 - i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_buf.sv
// Two-bank ping-pong sample store.
// The top address bit selects the bank; the low bits index within the bank.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i   single write port
//   rd_en_i/rd_addr_i    single read port; rd_data_o is registered and holds
//                        its value between reads
module fft_pingpong_buf #(
  parameter int unsigned Depth = 32,
  parameter int unsigned Width = 8,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Aw:0]      wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [Aw:0]      rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem [2*Depth];
  logic [Width-1:0] rd_data_q;

  // Sample storage is never cleared; validity is tracked by the full flags.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_frame_sched.sv
// FFT frame scheduler.
// Buffers upstream real samples into two ping-pong banks, feeds one full frame at
// a time to a streaming FFT, then labels the FFT's bit-reversed output stream with
// natural-order frequency indices. Only one frame is in the FFT at any time.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    upstream sample handshake
//   fft_valid_o/fft_x_o          registered frame samples to the FFT
//   fft_finish_i                 FFT output strobe, one sample per high cycle
//   out_valid/out_idx/out_last   downstream output tagging
//   err_timeout                  sticky: FFT did not respond within TIMEOUT cycles
module fft_frame_sched
  import fft_pkg::*;
#(
  parameter int unsigned N       = fft_pkg::N,
  parameter int unsigned DW      = fft_pkg::DW,
  parameter int unsigned TIMEOUT = fft_pkg::TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  output logic                 fft_valid_o,
  output logic [DW-1:0]        fft_x_o,
  input  logic                 fft_finish_i,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 err_timeout
);

  localparam int unsigned LW = $clog2(N);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  rd_state_e     state_q, state_d;
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, rd_bank_q;
  logic [LW-1:0] wr_ptr_q;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] k_q, k_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic          fft_valid_q, fft_valid_d;
  logic          rd_en, wr_fire, wr_last, rd_last;

  // in_ready depends only on registered flags, never on in_valid.
  assign in_ready = ~full_q[wr_bank_q];
  assign wr_fire  = in_valid & in_ready;
  assign wr_last  = wr_fire & (wr_ptr_q == LW'(N - 1));
  assign rd_last  = (state_q == StFeed) & (rd_ptr_q == LW'(N - 1));

  // Write and read always target different banks, so both updates can land together.
  always_comb begin
    full_d = full_q;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wait_d      = wait_q;
    k_d         = k_q;
    err_d       = err_q;
    fft_valid_d = 1'b0;
    rd_en       = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d  = StFeed;
          rd_ptr_d = '0;
        end
      end
      StFeed: begin
        // Read issued this cycle is presented to the FFT on the next cycle.
        rd_en       = 1'b1;
        fft_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + 1'b1;
        if (rd_last) begin
          state_d = StWait;
          wait_d  = '0;
        end
      end
      StWait, StDrain: begin
        // The finish pulse that ends WAIT already carries output k=0.
        if (fft_finish_i) begin
          out_valid = 1'b1;
          if (k_q == LW'(N - 1)) begin
            out_last = 1'b1;
            k_d      = '0;
            state_d  = StIdle;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = StDrain;
          end
        end else if (state_q == StWait) begin
          if (wait_q == WW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      k_q         <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      fft_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      rd_ptr_q    <= rd_ptr_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      fft_valid_q <= fft_valid_d;
      if (wr_fire) wr_ptr_q  <= wr_ptr_q + 1'b1;
      if (wr_last) wr_bank_q <= ~wr_bank_q;
      if (rd_last) rd_bank_q <= ~rd_bank_q;
    end
  end

  assign fft_valid_o = fft_valid_q;
  assign err_timeout = err_q;
  assign out_idx     = LW'(bitrev(32'(k_q), LW));

  fft_pingpong_buf #(
    .Depth(N),
    .Width(DW)
  ) u_buf (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .wr_en_i  (wr_fire),
    .wr_addr_i({wr_bank_q, wr_ptr_q}),
    .wr_data_i(in_data),
    .rd_en_i  (rd_en),
    .rd_addr_i({rd_bank_q, rd_ptr_q}),
    .rd_data_o(fft_x_o)
  );

endmodule

// File: tb/tb_fft_frame_sched.sv
// Randomized self-checking bench for fft_frame_sched.
// The reference model tracks samples accepted, frames fed and the FFT's response
// at transaction level and derives every expected output from those counts.
module tb_fft_frame_sched;

  localparam int N       = 32;
  localparam int DW      = 8;
  localparam int LW      = 5;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          fft_finish_i = 1'b0;
  logic          in_ready, fft_valid_o, out_valid, out_last, err_timeout;
  logic [DW-1:0] fft_x_o;
  logic [LW-1:0] out_idx;

  always #5 clk = ~clk;

  fft_frame_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .fft_valid_o (fft_valid_o),
    .fft_x_o     (fft_x_o),
    .fft_finish_i(fft_finish_i),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .err_timeout (err_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] acc_q[$];
  int frames_started, frames_released, fed_cnt, w, out_cnt, resp_delay, gap, gap_left;
  bit busy, responded, err_exp, gap_armed;
  // Stimulus knobs.
  int push_left, in_rate, fin_rate, stray_rate, gap_at;
  bit stall, seq_data;

  function automatic int ref_bitrev(input int k);
    int r, v;
    r = 0;
    v = k;
    for (int i = 0; i < LW; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic model_clear();
    acc_q.delete();
    frames_started = 0; frames_released = 0; fed_cnt = 0; w = 0; out_cnt = 0;
    gap = 0; gap_left = 0; gap_armed = 0; busy = 0; responded = 0; err_exp = 0;
    push_left = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    fft_finish_i = 1'b0;
    #1;
    check_eq("rst_fft_valid", fft_valid_o, 0);
    check_eq("rst_fft_x", fft_x_o, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("rst_in_ready", in_ready, 1);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    int idx, held;
    bit fin, exp_v;
    @(negedge clk);
    if (busy && !responded) begin
      w++;
      if (w >= TIMEOUT) begin
        err_exp = 1'b1;
        busy = 1'b0;
      end
    end
    check_eq("err_timeout", err_timeout, err_exp);

    if (fed_cnt > 0) begin
      idx = (frames_started - 1) * N + fed_cnt;
      check_eq("fft_valid_run", fft_valid_o, 1);
      check_eq("fft_x", fft_x_o, acc_q[idx]);
      fed_cnt++;
      if (fed_cnt == N) begin
        fed_cnt = 0;
        frames_released++;
        busy = 1'b1;
        responded = 1'b0;
        w = 0;
        out_cnt = 0;
        resp_delay = stall ? 1000 : $urandom_range(0, 40);
      end
    end else if (busy || acc_q.size() < (frames_started + 1) * N) begin
      check_eq("fft_valid_idle", fft_valid_o, 0);
      gap = 0;
    end else if (fft_valid_o) begin
      check_eq("feed_latency_le2", gap <= 2, 1);
      frames_started++;
      gap = 0;
      check_eq("fft_x", fft_x_o, acc_q[(frames_started - 1) * N]);
      fed_cnt = 1;
    end else begin
      gap++;
      if (gap > 6) begin
        check_eq("feed_start", fft_valid_o, 1);
        gap = 0;
      end
    end

    held = acc_q.size() - frames_released * N;
    check_eq("in_ready", in_ready, held < 2 * N);

    if (busy && responded && gap_armed && out_cnt == gap_at) begin
      gap_armed = 1'b0;
      gap_left = 3;
    end
    if (busy) begin
      if (!responded) fin = (w >= resp_delay);
      else if (gap_left > 0) begin
        fin = 1'b0;
        gap_left--;
      end else fin = ($urandom_range(0, 99) < fin_rate);
    end else begin
      fin = ($urandom_range(0, 99) < stray_rate);
    end
    fft_finish_i = fin;

    in_valid = (push_left > 0) && ($urandom_range(0, 99) < in_rate);
    in_data = seq_data ? DW'(acc_q.size()) : DW'($urandom);
    if (in_valid && in_ready) begin
      acc_q.push_back(in_data);
      push_left--;
    end

    #1;
    exp_v = fin && busy;
    check_eq("out_valid", out_valid, exp_v);
    check_eq("out_idx", out_idx, ref_bitrev(busy ? out_cnt : 0));
    check_eq("out_last", out_last, exp_v && out_cnt == N - 1);
    if (exp_v) begin
      responded = 1'b1;
      out_cnt++;
      if (out_cnt == N) begin
        busy = 1'b0;
        out_cnt = 0;
      end
    end
  endtask

  task automatic run_phase(input int budget);
    int cyc;
    cyc = 0;
    while ((push_left > 0 || busy || fed_cnt > 0 || acc_q.size() >= (frames_started + 1) * N)
           && cyc < budget) begin
      step();
      cyc++;
    end
    check_eq("phase_done", cyc < budget, 1);
    repeat (3) step();
  endtask

  initial begin
    int cyc;
    model_clear();
    in_rate = 100; fin_rate = 100; stray_rate = 0; gap_at = -1; stall = 0; seq_data = 1;
    #3;
    do_reset();

    // One frame of 0..31, back-to-back.
    push_left = 32;
    run_phase(500);

    // Two frames continuously; second frame must wait for the first drain.
    seq_data = 0;
    push_left = 64;
    run_phase(800);

    // Drain with a 3-cycle finish gap after the 10th output.
    gap_at = 10; gap_armed = 1'b1;
    push_left = 32;
    run_phase(500);
    gap_at = -1;

    // FFT never responds: back-pressure, timeouts, frames dropped.
    stall = 1;
    push_left = 96;
    run_phase(1500);
    stall = 0;

    // Random traffic with stray finish pulses outside WAIT/DRAIN.
    do_reset();
    in_rate = 60; fin_rate = 70; stray_rate = 20;
    push_left = 8 * N;
    run_phase(8000);

    // Reset in the middle of a feed.
    in_rate = 100; fin_rate = 100; stray_rate = 0;
    push_left = N;
    cyc = 0;
    while (fed_cnt != 10 && cyc < 300) begin
      step();
      cyc++;
    end
    check_eq("reach_feed10", fed_cnt, 10);
    do_reset();
    step();
    check_eq("in_ready_after_release", in_ready, 1);

    // Recovery after reset.
    push_left = N;
    run_phase(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_frame_sched.md
FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 Parameters SHALL be, one per line:
- N, 32, samples per FFT frame (power of 2).
- DW, 8, input sample width.
- TIMEOUT, 64, maximum cycles allowed from the last fed sample to the first fft_finish_i.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, upstream sample valid.
- in_ready, out, 1, scheduler can accept a sample.
- in_data, in, DW, upstream real sample.
- fft_valid_o, out, 1, drives FFT valid_i.
- fft_x_o, out, DW, drives FFT x_r.
- fft_finish_i, in, 1, FFT finish (one output sample per high cycle).
- out_valid, out, 1, current FFT output sample is valid for downstream.
- out_idx, out, log2(N), natural-order frequency index of the current FFT output.
- out_last, out, 1, marks the N-th output of a frame.
- err_timeout, out, 1, sticky error flag for FFT no-response.

Function
REQ-003 An input sample SHALL transfer when in_valid && in_ready on a rising edge, with no combinational path from in_valid to in_ready.
REQ-004 Storage SHALL be two banks (ping-pong) of N x DW, with per-bank full flags.
REQ-005 The write pointer SHALL fill bank wr_bank at addresses 0..N-1.
REQ-006 On the N-th write: full[wr_bank] SHALL set and wr_bank SHALL toggle.
REQ-007 in_ready SHALL equal !full[wr_bank].
REQ-008 The read FSM SHALL have states IDLE, FEED, WAIT and DRAIN.
REQ-009 IDLE -> FEED SHALL occur when full[rd_bank] is set.
REQ-010 FEED SHALL assert fft_valid_o for exactly N consecutive cycles, carrying bank[rd_bank][0..N-1] in order, all registered.
REQ-011 On the cycle the N-th sample is driven: full[rd_bank] SHALL clear, rd_bank SHALL toggle, and the FSM SHALL go to WAIT.
REQ-012 If a write completes one bank in the same cycle a read frees the other bank, both flag updates SHALL apply.
REQ-013 A write and a feed to the same bank SHALL never occur.
REQ-014 WAIT SHALL count cycles and go to DRAIN on the first fft_finish_i=1.
REQ-015 If the WAIT count reaches TIMEOUT with no fft_finish_i, the block SHALL set err_timeout and return to IDLE; the frame is dropped.
REQ-016 In DRAIN, out_valid SHALL equal fft_finish_i combinationally.
REQ-017 In DRAIN, output counter k SHALL advance only on finish-high cycles.
REQ-018 out_idx SHALL be bitrev(k), because the FFT emits in bit-reversed order.
REQ-019 out_last SHALL be 1 when k=N-1 and finish=1; after that output the FSM SHALL go to IDLE.
REQ-020 fft_finish_i in IDLE or FEED SHALL be ignored (out_valid=0).
REQ-021 Only one frame SHALL be in flight in the FFT; FEED of the next frame SHALL wait for DRAIN to complete.
REQ-022 Input loading SHALL continue during FEED, WAIT and DRAIN whenever a bank is free.
REQ-023 err_timeout SHALL remain set until reset.

Reset
REQ-024 rst_n low SHALL asynchronously set:
- FSM = IDLE, wr_bank = rd_bank = 0, full = 00;
- all pointers and counters = 0;
- fft_valid_o = 0, fft_x_o = 0, out_valid = 0, out_idx = 0, out_last = 0, err_timeout = 0;
- in_ready = 1 on the first cycle after release.
REQ-025 Reset mid-frame SHALL discard all buffered samples; bank memory contents need not be cleared.

Structure
REQ-026 A shared package fft_pkg SHALL hold N, DW, LOG2N, TIMEOUT default and the FSM state enum.
REQ-027 Storage SHALL be one sub-module, fft_pingpong_buf (two banks: one write port, one read port, registered read).
REQ-028 bitrev SHALL be a package function.

Verification
REQ-029 After reset, push 32 samples 0..31 back-to-back -> FEED follows within 2 cycles, and fft_valid_o is high 32 consecutive cycles with fft_x_o = 0..31.
REQ-030 Push 64 samples continuously -> in_ready never drops, and the second frame feeds only after the first DRAIN emits 32 outputs with out_last on the 32nd.
REQ-031 Push 96 samples with FFT stalled -> in_ready=0 after 64 accepted, and it reasserts one cycle after the first FEED completes.
REQ-032 Drive finish for 32 cycles in DRAIN -> out_idx sequence 0,16,8,24,4,...,31, and out_valid tracks finish including a mid-drain 3-cycle gap.
REQ-033 Never assert finish after FEED -> err_timeout=1 exactly TIMEOUT=64 cycles after the last fed sample, FSM returns to IDLE, and the next full bank feeds.
REQ-034 Assert rst_n=0 at FEED sample 10 -> all outputs zero immediately, and in_ready=1 after release.
